// File: rtl/modn_pkg.sv
// Shared definitions for the mod-N counter, its downstream tracker and benches.
package modn_pkg;

    // Tracker FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Direction encoding of the counter's upordown input.
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Default counter geometry shared with the mod-N counter.
    localparam int DEF_N = 10;
    localparam int DEF_W = 4;

    // One-hot classification of a single count transition.
    typedef struct packed {
        logic hold;
        logic up;
        logic carry;
        logic down;
        logic borrow;
        logic illegal;
    } step_t;

endpackage

// File: rtl/modn_step_check.sv
// Classifies one observed count transition p -> c under direction dir_q.
module modn_step_check
    import modn_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic [W-1:0] p,
    input  logic [W-1:0] c,
    input  logic         dir_q,
    output step_t        step
);

    // One extra bit so that N = 2^W is still representable.
    localparam logic [W:0]   N_EXT = (W+1)'(N);
    localparam logic [W:0]   ONE   = (W+1)'(1);
    localparam logic [W-1:0] LAST  = W'(N - 1);

    logic [W:0] p_ext;
    logic [W:0] c_ext;

    assign p_ext = {1'b0, p};
    assign c_ext = {1'b0, c};

    // Priority-ordered classification; exactly one flag is set.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        step = '0;
        if (c_ext >= N_EXT) begin
            step.illegal = 1'b1;
        end else if (c == p) begin
            step.hold = 1'b1;
        end else if (dir_q == UP && p_ext < N_EXT - ONE && c_ext == p_ext + ONE) begin
            step.up = 1'b1;
        end else if (dir_q == UP && p == LAST && c == '0) begin
            step.carry = 1'b1;
        end else if (dir_q == DOWN && p != '0 && c_ext == p_ext - ONE) begin
            step.down = 1'b1;
        end else if (dir_q == DOWN && p == '0 && c == LAST) begin
            step.borrow = 1'b1;
        end else begin
            step.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/modn_wrap_tracker.sv
// Monitors a mod-N up/down counter: counts net wraps, flags illegal steps.
module modn_wrap_tracker
    import modn_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int W    = DEF_W,
    parameter int HI_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            src_reset,
    input  logic [W-1:0]    count_in,
    input  logic            upordown,
    output logic            carry_pulse,
    output logic            borrow_pulse,
    output logic            dir_change,
    output logic [HI_W-1:0] wrap_count,
    output logic            step_err,
    output logic            tracking
);

    state_t       state;
    state_t       state_n;
    logic [W-1:0] prev_cnt;
    logic         dir_q;
    step_t        step;
    logic         do_carry;
    logic         do_borrow;
    logic         set_err;

    modn_step_check #(
        .N (N),
        .W (W)
    ) u_step_check (
        .p     (prev_cnt),
        .c     (count_in),
        .dir_q (dir_q),
        .step  (step)
    );

    // Next-state and event decode; src_reset pre-empts any step check.
    always_comb begin
        state_n   = state;
        do_carry  = 1'b0;
        do_borrow = 1'b0;
        set_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!src_reset) state_n = TRACK;
            end
            TRACK: begin
                if (src_reset) begin
                    state_n = IDLE;
                end else if (step.illegal) begin
                    state_n = ERR;
                    set_err = 1'b1;
                end else begin
                    do_carry  = step.carry;
                    do_borrow = step.borrow;
                end
            end
            ERR:     state_n = ERR;
            default: state_n = IDLE;
        endcase
    end

    // State register; only reset leaves ERR.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Datapath registers: previous count, direction, pulses, wrap tally, error.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cnt     <= '0;
            dir_q        <= DOWN;
            dir_change   <= 1'b0;
            carry_pulse  <= 1'b0;
            borrow_pulse <= 1'b0;
            wrap_count   <= '0;
            step_err     <= 1'b0;
        end else begin
            dir_q        <= upordown;
            dir_change   <= (state != ERR) && (upordown != dir_q);
            carry_pulse  <= do_carry;
            borrow_pulse <= do_borrow;
            step_err     <= step_err | set_err;
            if (state != ERR) prev_cnt <= src_reset ? '0 : count_in;
            if (do_carry)       wrap_count <= wrap_count + 1'b1;
            else if (do_borrow) wrap_count <= wrap_count - 1'b1;
        end
    end

    assign tracking = (state == TRACK);

endmodule

// File: tb/tb_modn_wrap_tracker.sv
// Scoreboard bench for modn_wrap_tracker with N = 10, W = 4, HI_W = 8.
module tb_modn_wrap_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       src_reset;
    logic [3:0] count_in;
    logic       upordown;
    logic       carry_pulse;
    logic       borrow_pulse;
    logic       dir_change;
    logic [7:0] wrap_count;
    logic       step_err;
    logic       tracking;

    typedef struct {
        logic       carry;
        logic       borrow;
        logic       dchg;
        logic [7:0] wrap;
        logic       err;
        logic       trk;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    modn_wrap_tracker #(
        .N    (10),
        .W    (4),
        .HI_W (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_reset    (src_reset),
        .count_in     (count_in),
        .upordown     (upordown),
        .carry_pulse  (carry_pulse),
        .borrow_pulse (borrow_pulse),
        .dir_change   (dir_change),
        .wrap_count   (wrap_count),
        .step_err     (step_err),
        .tracking     (tracking)
    );

    always #10 clk = ~clk;

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (carry_pulse !== e.carry || borrow_pulse !== e.borrow ||
                dir_change !== e.dchg || wrap_count !== e.wrap ||
                step_err !== e.err || tracking !== e.trk) begin
                n_fail++;
                $display("FAIL %s: got c=%0b b=%0b d=%0b w=%02h e=%0b t=%0b, expected c=%0b b=%0b d=%0b w=%02h e=%0b t=%0b",
                         e.tag, carry_pulse, borrow_pulse, dir_change, wrap_count, step_err, tracking,
                         e.carry, e.borrow, e.dchg, e.wrap, e.err, e.trk);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [3:0] cnt,
                        input logic ec, input logic eb, input logic ed, input logic [7:0] ew,
                        input logic ee, input logic et, input string tag);
        exp_t e;
        reset     = r;
        src_reset = s;
        upordown  = d;
        count_in  = cnt;
        e.carry = ec; e.borrow = eb; e.dchg = ed; e.wrap = ew;
        e.err = ee; e.trk = et; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Legal up steps from..to with no events.
    task automatic run_up(input int from, input int to, input logic [7:0] w);
        for (int i = from; i <= to; i++) step(0, 0, 1, 4'(i), 0, 0, 0, w, 0, 1, "count_up");
    endtask

    // Legal down steps from..to with no events.
    task automatic run_down(input int from, input int to, input logic [7:0] w);
        for (int i = from; i >= to; i--) step(0, 0, 0, 4'(i), 0, 0, 0, w, 0, 1, "count_down");
    endtask

    initial begin
        // Reset for three cycles, then counter runs up with one carry per ten counts.
        repeat (3) step(1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, "reset");
        step(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 1, "idle_to_track");
        run_up(1, 9, 8'h00);
        step(0, 0, 1, 0, 1, 0, 0, 8'h01, 0, 1, "carry_first");
        run_up(1, 3, 8'h01);

        // Switch down at 3, borrow on 0 -> 9.
        step(0, 0, 0, 3, 0, 0, 1, 8'h01, 0, 1, "dir_to_down");
        run_down(2, 0, 8'h01);
        step(0, 0, 0, 9, 0, 1, 0, 8'h00, 0, 1, "borrow_to_0");
        run_down(8, 0, 8'h00);
        step(0, 0, 0, 9, 0, 1, 0, 8'hFF, 0, 1, "borrow_to_ff");

        // Switch up at 9, carry back from FF to 00, then one more carry.
        step(0, 0, 1, 9, 0, 0, 1, 8'hFF, 0, 1, "dir_to_up");
        step(0, 0, 1, 0, 1, 0, 0, 8'h00, 0, 1, "carry_ff_to_00");
        run_up(1, 9, 8'h00);
        step(0, 0, 1, 0, 1, 0, 0, 8'h01, 0, 1, "carry_second");
        run_up(1, 6, 8'h01);

        // Upstream reset at 6: counter returns to 0, no error, wrap kept.
        step(0, 1, 1, 0, 0, 0, 0, 8'h01, 0, 0, "src_reset");
        step(0, 0, 1, 0, 0, 0, 0, 8'h01, 0, 1, "resync");
        run_up(1, 4, 8'h01);

        // Jump 4 -> 7 is illegal; later wraps are ignored; src_reset cannot clear.
        step(0, 0, 1, 7, 0, 0, 0, 8'h01, 1, 0, "jump_4_7");
        step(0, 0, 1, 8, 0, 0, 0, 8'h01, 1, 0, "err_hold_8");
        step(0, 0, 1, 9, 0, 0, 0, 8'h01, 1, 0, "err_hold_9");
        step(0, 0, 1, 0, 0, 0, 0, 8'h01, 1, 0, "err_no_carry");
        step(0, 1, 1, 0, 0, 0, 0, 8'h01, 1, 0, "err_src_reset");
        step(0, 0, 0, 0, 0, 0, 0, 8'h01, 1, 0, "err_no_dchg");
        step(1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, "reset_clears_err");

        // Out-of-range value.
        step(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 1, "idle_value12");
        step(0, 0, 1, 1, 0, 0, 0, 8'h00, 0, 1, "up_value12");
        step(0, 0, 1, 12, 0, 0, 0, 8'h00, 1, 0, "value_12");
        step(0, 0, 1, 12, 0, 0, 0, 8'h00, 1, 0, "value_12_sticky");
        step(1, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0, "reset_after_12");

        // Down step while direction says up.
        step(0, 0, 1, 5, 0, 0, 1, 8'h00, 0, 1, "idle_against");
        step(0, 0, 1, 4, 0, 0, 0, 8'h00, 1, 0, "step_5_4_up");
        step(1, 0, 1, 3, 0, 0, 0, 8'h00, 0, 0, "reset_after_against");

        // Direction toggles while count holds.
        step(0, 0, 1, 3, 0, 0, 1, 8'h00, 0, 1, "toggle_idle");
        step(0, 0, 0, 3, 0, 0, 1, 8'h00, 0, 1, "toggle_down");
        step(0, 0, 1, 3, 0, 0, 1, 8'h00, 0, 1, "toggle_up");
        step(0, 0, 1, 3, 0, 0, 0, 8'h00, 0, 1, "toggle_steady");
        step(0, 0, 0, 3, 0, 0, 1, 8'h00, 0, 1, "toggle_down2");
        step(0, 0, 0, 3, 0, 0, 0, 8'h00, 0, 1, "toggle_steady2");

        // Let the monitor consume the last entry, then confirm nothing is left.
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
